// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the ARM multicycle controller: FSM states, datapath
// select codes, condition codes and the data-processing command decoder.
package arm_ctrl_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_FETCH  = 4'd0;
  localparam state_t S_DECODE = 4'd1;
  localparam state_t S_MEMADR = 4'd2;
  localparam state_t S_MEMRD  = 4'd3;
  localparam state_t S_MEMWB  = 4'd4;
  localparam state_t S_MEMWR  = 4'd5;
  localparam state_t S_EXECR  = 4'd6;
  localparam state_t S_EXECI  = 4'd7;
  localparam state_t S_ALUWB  = 4'd8;
  localparam state_t S_BRANCH = 4'd9;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  typedef struct packed {
    logic [1:0] alu;
    logic       reg_wr;
    logic       flag_wr;
    logic       cv_wr;
  } dp_dec_t;

  // Maps funct[4:1] plus the S bit onto ALU op, register write and flag writes.
  function automatic dp_dec_t decode_cmd(input logic [3:0] cmd, input logic s_bit);
    dp_dec_t d;
    d = '{alu: ALU_ADD, reg_wr: 1'b0, flag_wr: 1'b0, cv_wr: 1'b0};
    case (cmd)
      4'b0100: d = '{alu: ALU_ADD, reg_wr: 1'b1, flag_wr: s_bit, cv_wr: 1'b1};
      4'b0010: d = '{alu: ALU_SUB, reg_wr: 1'b1, flag_wr: s_bit, cv_wr: 1'b1};
      4'b0000: d = '{alu: ALU_AND, reg_wr: 1'b1, flag_wr: s_bit, cv_wr: 1'b0};
      4'b1100: d = '{alu: ALU_ORR, reg_wr: 1'b1, flag_wr: s_bit, cv_wr: 1'b0};
      4'b1010: d = '{alu: ALU_SUB, reg_wr: 1'b0, flag_wr: 1'b1,  cv_wr: 1'b1};
      default: d = '{alu: ALU_ADD, reg_wr: 1'b0, flag_wr: 1'b0,  cv_wr: 1'b0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cond_unit.sv
// NZCV flag register, condition evaluation and the CondExR latch that gates
// every conditional side effect of the current instruction.
module cond_unit
  import arm_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic       latch_i,
  input  logic       flag_wr_i,
  input  logic       cv_wr_i,
  output logic       cond_ex_o
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex_q, cond_ex_d;
  logic       cond_met_s;
  logic       n_s, z_s, c_s, v_s;

  assign {n_s, z_s, c_s, v_s} = flags_q;
  assign cond_ex_o = cond_ex_q;

  // Condition-code evaluation against the architectural flags.
  always_comb begin
    cond_met_s = 1'b0;
    case (cond_i)
      COND_EQ: cond_met_s = z_s;
      COND_NE: cond_met_s = ~z_s;
      COND_CS: cond_met_s = c_s;
      COND_CC: cond_met_s = ~c_s;
      COND_MI: cond_met_s = n_s;
      COND_PL: cond_met_s = ~n_s;
      COND_VS: cond_met_s = v_s;
      COND_VC: cond_met_s = ~v_s;
      COND_HI: cond_met_s = c_s & ~z_s;
      COND_LS: cond_met_s = ~c_s | z_s;
      COND_GE: cond_met_s = (n_s == v_s);
      COND_LT: cond_met_s = (n_s != v_s);
      COND_GT: cond_met_s = ~z_s & (n_s == v_s);
      COND_LE: cond_met_s = z_s | (n_s != v_s);
      COND_AL: cond_met_s = 1'b1;
      default: cond_met_s = 1'b0;
    endcase
  end

  // Next-state for flags (NZ always, CV only for arithmetic ops) and CondExR.
  always_comb begin
    flags_d = flags_q;
    if (flag_wr_i && cond_ex_q) begin
      flags_d[3:2] = alu_flags_i[3:2];
      if (cv_wr_i) begin
        flags_d[1:0] = alu_flags_i[1:0];
      end else begin
        flags_d[1:0] = flags_q[1:0];
      end
    end else begin
      flags_d = flags_q;
    end
    if (latch_i) begin
      cond_ex_d = cond_met_s;
    end else begin
      cond_ex_d = cond_ex_q;
    end
  end

  // Flag and CondExR registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARMv4-subset control unit: main FSM and instruction decoder;
// flags and condition checking live in cond_unit.
module arm_mc_controller
  import arm_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [31:12] Instr,
  input  logic [3:0]   ALUFlags,
  output logic         PCWrite,
  output logic         MemWrite,
  output logic         RegWrite,
  output logic         IRWrite,
  output logic         AdrSrc,
  output logic [1:0]   RegSrc,
  output logic         ALUSrcA,
  output logic [1:0]   ALUSrcB,
  output logic [1:0]   ResultSrc,
  output logic [1:0]   ImmSrc,
  output logic [1:0]   ALUControl
);

  state_t     state_q, state_d;
  logic [3:0] cond_s;
  logic [1:0] op_s;
  logic [5:0] funct_s;
  logic       rd15_s;
  dp_dec_t    dec_s;
  logic       cond_ex_s;
  logic       en_s, gate_s;
  logic       flag_req_s;
  logic       unused_rn_s;

  assign cond_s      = Instr[31:28];
  assign op_s        = Instr[27:26];
  assign funct_s     = Instr[25:20];
  assign rd15_s      = (Instr[15:12] == 4'd15);
  assign unused_rn_s = ^Instr[19:16];
  assign dec_s       = decode_cmd(funct_s[4:1], funct_s[0]);

  // Reset forces all enables low immediately; conditional ones also need CondExR.
  assign en_s   = reset;
  assign gate_s = reset & cond_ex_s;

  assign ImmSrc     = op_s;
  assign RegSrc     = {(op_s == OP_MEM), (op_s == OP_BR)};
  assign flag_req_s = ((state_q == S_EXECR) || (state_q == S_EXECI)) && dec_s.flag_wr;

  cond_unit u_cond (
    .clk         (clk),
    .rst_n       (reset),
    .cond_i      (cond_s),
    .alu_flags_i (ALUFlags),
    .latch_i     (state_q == S_DECODE),
    .flag_wr_i   (flag_req_s),
    .cv_wr_i     (dec_s.cv_wr),
    .cond_ex_o   (cond_ex_s)
  );

  // Next-state logic of the main sequencer.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op_s)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = funct_s[5] ? S_EXECI : S_EXECR;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = funct_s[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // State-decoded datapath controls with CondExR / Rd==15 gating.
  always_comb begin
    PCWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    ResultSrc  = RES_ALUOUT;
    ALUControl = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        IRWrite   = en_s;
        PCWrite   = en_s;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_MEMADR: ALUSrcB = SRCB_IMM;
      S_MEMRD:  AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_MEMDATA;
        RegWrite  = gate_s;
        PCWrite   = gate_s & rd15_s;
      end
      S_MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = gate_s;
      end
      S_EXECR:  ALUControl = dec_s.alu;
      S_EXECI: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = dec_s.alu;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = gate_s & dec_s.reg_wr;
        PCWrite   = gate_s & dec_s.reg_wr & rd15_s;
      end
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        PCWrite   = gate_s;
      end
      default: begin
        PCWrite = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/arm_mc_controller.md
# arm_mc_controller

Multicycle control unit for the ARMv4 subset core: it sequences a shared-ALU, shared-memory datapath over 3–5 cycles per instruction. The datapath holds the instruction register, register file, ALU and result muxes. This block holds the main state machine, the instruction decoder, the condition-check unit and the NZCV flag register, and drives every datapath select and write enable.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (0 = reset)
- Instr  in  20  Instr[31:12] from the datapath instruction register: cond[31:28], op[27:26], funct[25:20], Rd[15:12]
- ALUFlags  in  4  {N,Z,C,V} from the ALU, current cycle
- PCWrite, MemWrite, RegWrite, IRWrite  out  1 each  write enables
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- RegSrc  out  2  [0]: RA1 = R15; [1]: RA2 = Rd
- ALUSrcA  out  1  0 = register A, 1 = PC
- ALUSrcB  out  2  00 = WriteData, 01 = ExtImm, 10 = constant 4
- ResultSrc  out  2  00 = ALUOut, 01 = memory data, 10 = ALUResult
- ImmSrc  out  2  00 = DP imm8, 01 = mem imm12, 10 = branch imm24
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1. Next state DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10. This produces PC+8 for R15 reads. Next state by op:
  - op=01 → MEMADR
  - op=00 with funct[5]=1 → EXECI; funct[5]=0 → EXECR
  - op=10 → BRANCH
  - op=11 → FETCH (NOP)
- MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. Next MEMRD if funct[0] (L), else MEMWR.
- MEMRD: AdrSrc=1 → MEMWB. MEMWB: ResultSrc=01, RegWrite → FETCH.
- MEMWR: AdrSrc=1, MemWrite → FETCH.
- EXECR / EXECI: ALUSrcA=0, ALUSrcB 00 / 01, ALUControl from cmd → ALUWB. ALUWB: ResultSrc=00, RegWrite → FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite → FETCH.
- cmd = funct[4:1] maps as follows:
  - 0100 → ADD
  - 0010 → SUB
  - 0000 → AND
  - 1100 → ORR
  - 1010 → CMP: SUB, no register write, flags always written
  - any other cmd → NOP: ADD, no register write, no flag write
- ImmSrc = op. RegSrc[0] = (op==10). RegSrc[1] = (op==01).
- Condition: all 14 ARMv4 codes 0000–1101 are evaluated. 1110 (AL) is true. 1111 is false.
- CondExR is latched at the end of DECODE from the flag register. Every later write enable (RegWrite, MemWrite, branch PCWrite, flag write) is ANDed with CondExR. FETCH PCWrite and IRWrite are unconditional.
- Flag write: at the end of EXECR/EXECI, when S=funct[0] (or CMP) and CondExR.
  - NZ is written for all ops.
  - CV is written for ADD/SUB/CMP only.
- Rd=15 in ALUWB or MEMWB: PCWrite is also asserted with RegWrite (when CondExR).

## Timing
- While reset=0: state=FETCH, flags=0000, CondExR=0, and all write enables forced 0. On release, the first FETCH occurs at the next edge.
- Reset asserted mid-instruction aborts it immediately; no partial writes after assertion.
- Cycle counts: LDR 5, STR 4, DP 4, B 3, op=11 2. Failed-condition instructions keep the same cycle count with no side effects.
- Outputs are Moore (state-decoded) except for gating by CondExR and Rd==15.

## Structure
- Package arm_ctrl_pkg holds the state enum and the ALUControl, ImmSrc, ResultSrc, ALUSrcB and cond-code constants.
- Sub-module cond_unit holds the NZCV register, the condition evaluation, the CondExR latch and the flag-write split.
- The FSM and decoder stay in the top module.

## Test plan
- Reset held mid-MEMWR with Instr=0xE58… → MemWrite drops the same cycle. After release: state FETCH, flags 0000.
- ADDS with R1+R2 overflowing (ALUFlags=0011) → 4 cycles, RegWrite only in ALUWB, flags become 0011.
- SUBEQ with Z=0 → 4 cycles, RegWrite, PCWrite and flag write never asserted.
- CMP (cond AL) → RegWrite never asserted; next BEQ with ALUFlags Z=1 → PCWrite in BRANCH, 3 cycles total.
- LDR with Rd=15 → 5 cycles, MEMWB asserts RegWrite and PCWrite, ResultSrc=01.
- ANDS with ALUFlags=1001 → NZ=10 written, CV keeps its prior value.
